// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared datapath widths and ALU opcode encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;
    localparam int REG_AW = 3;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_NOR   = 4'b0101,
        ALU_NAND  = 4'b0110,
        ALU_XNOR  = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SLT   = 4'b1011,
        ALU_SLTU  = 4'b1100,
        ALU_PASSA = 4'b1101,
        ALU_PASSB = 4'b1110
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
// ============================================================================
// Module   : fwd_mux
// Brief    : Operand bypass select: EX/MEM result, else MEM/WB result, else the
//            register-file value. Built only when ID_EX_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef ID_EX_FWD_EN
module fwd_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_rf_val,
    input  logic              i_exm_valid,
    input  logic              i_exm_rd_we,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [DATA_W-1:0] i_exm_result,
    input  logic              i_wb_valid,
    input  logic              i_wb_rd_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_result,
    output logic [DATA_W-1:0] o_val
);
    import cpu_pkg::*;

    logic w_exm_hit;
    logic w_wb_hit;

    // Register 0 is hard-wired, so it never participates in a bypass.
    assign w_exm_hit = (i_src != '0) && i_exm_valid && i_exm_rd_we && (i_exm_rd == i_src);
    assign w_wb_hit  = (i_src != '0) && i_wb_valid  && i_wb_rd_we  && (i_wb_rd  == i_src);

    always_comb begin
        o_val = i_rf_val;
        if (w_exm_hit) begin
            o_val = i_exm_result;
        end else if (w_wb_hit) begin
            o_val = i_wb_result;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with operand bypass (ID_EX_FWD_EN) or
//            source-hazard interlock (macro undefined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int OP_W   = cpu_pkg::OP_W,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic [DATA_W-1:0] id_rs1_val,
    input  logic [DATA_W-1:0] id_rs2_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              stall,
    input  logic              flush,
    input  logic              exm_valid,
    input  logic              exm_rd_we,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_valid,
    input  logic              wb_rd_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [OP_W-1:0]   ex_opcode,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_we
);
    import cpu_pkg::*;

    logic              valid_q,   valid_d;
    logic [OP_W-1:0]   opcode_q,  opcode_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic              rd_we_q,   rd_we_d;
    logic [DATA_W-1:0] rs1_val_q, rs1_val_d;
    logic [DATA_W-1:0] rs2_val_q, rs2_val_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic              use_imm_q, use_imm_d;
    logic              w_hazard;
    logic              w_capture;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b_reg;

`ifdef ID_EX_FWD_EN
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;

    assign w_hazard = 1'b0;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .i_src(rs1_q), .i_rf_val(rs1_val_q),
        .i_exm_valid(exm_valid), .i_exm_rd_we(exm_rd_we), .i_exm_rd(exm_rd), .i_exm_result(exm_result),
        .i_wb_valid(wb_valid), .i_wb_rd_we(wb_rd_we), .i_wb_rd(wb_rd), .i_wb_result(wb_result),
        .o_val(w_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .i_src(rs2_q), .i_rf_val(rs2_val_q),
        .i_exm_valid(exm_valid), .i_exm_rd_we(exm_rd_we), .i_exm_rd(exm_rd), .i_exm_result(exm_result),
        .i_wb_valid(wb_valid), .i_wb_rd_we(wb_rd_we), .i_wb_rd(wb_rd), .i_wb_result(wb_result),
        .o_val(w_b_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (!flush && !stall && w_capture) begin
            rs1_d = id_rs1;
            rs2_d = id_rs2;
        end
    end
`else
    logic w_unused_results;

    function automatic logic src_hit(input logic [REG_AW-1:0] src, input logic v,
                                     input logic we, input logic [REG_AW-1:0] rd);
        return (src != '0) && v && we && (rd == src);
    endfunction

    // Without bypass paths, any in-flight producer of a source blocks capture.
    assign w_hazard = id_valid && (
           src_hit(id_rs1, ex_valid, ex_rd_we, ex_rd)
        || src_hit(id_rs1, exm_valid, exm_rd_we, exm_rd)
        || src_hit(id_rs1, wb_valid, wb_rd_we, wb_rd)
        || (!id_use_imm && (src_hit(id_rs2, ex_valid, ex_rd_we, ex_rd)
                         || src_hit(id_rs2, exm_valid, exm_rd_we, exm_rd)
                         || src_hit(id_rs2, wb_valid, wb_rd_we, wb_rd))));

    assign w_a              = rs1_val_q;
    assign w_b_reg          = rs2_val_q;
    assign w_unused_results = ^{exm_result, wb_result};
`endif

    assign id_ready  = !stall && (rst || !w_hazard);
    assign w_capture = id_valid && id_ready;

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            if (w_capture) begin
                valid_d   = 1'b1;
                opcode_d  = id_opcode;
                rd_d      = id_rd;
                rd_we_d   = id_rd_we;
                rs1_val_d = id_rs1_val;
                rs2_val_d = id_rs2_val;
                imm_d     = id_imm;
                use_imm_d = id_use_imm;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_opcode = opcode_q;
    assign ex_rd     = rd_q;
    assign ex_rd_we  = rd_we_q && valid_q;
    assign ex_a      = w_a;
    assign ex_b      = use_imm_q ? imm_q : w_b_reg;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Self-checking bench for id_ex_stage (both ID_EX_FWD_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
    localparam int DW = 16;
    localparam int OW = 4;
    localparam int AW = 3;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [AW-1:0] rd;
        logic          we;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, id_rd_we, id_use_imm, stall, flush;
    logic [OW-1:0] id_opcode;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
    logic [DW-1:0] id_rs1_val, id_rs2_val, id_imm, exm_result, wb_result;
    logic          exm_valid, exm_rd_we, wb_valid, wb_rd_we;
    logic          id_ready, ex_valid, ex_rd_we;
    logic [DW-1:0] ex_a, ex_b;
    logic [OW-1:0] ex_opcode;
    logic [AW-1:0] ex_rd;

    int   vectors     = 0;
    int   miscompares = 0;
    out_t sb[$];
    out_t exp_o;
    out_t held_o;
    out_t obs_o;

    assign obs_o = {ex_valid, ex_a, ex_b, ex_opcode, ex_rd, ex_rd_we};

    id_ex_stage #(.DATA_W(DW), .OP_W(OW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .stall(stall), .flush(flush),
        .exm_valid(exm_valid), .exm_rd_we(exm_rd_we), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd(wb_rd), .wb_result(wb_result),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_we = 0;
        id_rs1_val = '0; id_rs2_val = '0; id_imm = '0; id_use_imm = 0;
        stall = 0; flush = 0;
        exm_valid = 0; exm_rd_we = 0; exm_rd = '0; exm_result = '0;
        wb_valid = 0; wb_rd_we = 0; wb_rd = '0; wb_result = '0;
    endtask

    task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we, input logic [DW-1:0] v1,
                         input logic [DW-1:0] v2, input logic [DW-1:0] imm, input logic use_imm);
        id_valid = 1; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_we = we;
        id_rs1_val = v1; id_rs2_val = v2; id_imm = imm; id_use_imm = use_imm;
    endtask

    task automatic push_exp(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op,
                            input logic [AW-1:0] rd, input logic we);
        sb.push_back({1'b1, a, b, op, rd, we});
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; stall = 1;
        issue(4'hF, 3'd7, 3'd7, 3'd7, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        #1;
        vectors++;
        if (id_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready_stalled: got %b want 0", id_ready);
        end
        step();
        stall = 0;
        step();
        vectors++;
        if (obs_o !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", obs_o);
        end
        vectors++;
        if (id_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b want 1", id_ready);
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_capture();
        logic [DW-1:0] sum;
        idle_inputs(); step();
        issue(4'b0000, 3'd1, 3'd2, 3'd5, 1'b1, 16'd10, 16'd20, 16'h0099, 1'b0);
        #1;
        vectors++;
        if (id_ready !== 1'b1) begin
            miscompares++; $display("FAIL capture_ready: got %b want 1", id_ready);
        end
        push_exp(16'd10, 16'd20, 4'b0000, 3'd5, 1'b1);
        step();
        id_valid = 0;
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL capture: got %h want %h", obs_o, exp_o);
        end
        sum = ex_a + ex_b; vectors++;
        if (sum !== 16'd30) begin
            miscompares++; $display("FAIL alu_add: got %0d want 30", sum);
        end
        step();
        vectors++;
        if ({ex_valid, ex_rd_we} !== 2'b00) begin
            miscompares++; $display("FAIL bubble: got %b want 00", {ex_valid, ex_rd_we});
        end
    endtask

`ifdef ID_EX_FWD_EN
    task automatic test_bypass();
        idle_inputs(); step();
        issue(4'b0001, 3'd3, 3'd6, 3'd1, 1'b1, 16'h0007, 16'h0008, 16'h0000, 1'b0);
        push_exp(16'h0007, 16'h0008, 4'b0001, 3'd1, 1'b1);
        step();
        id_valid = 0;
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL bypass_capture: got %h want %h", obs_o, exp_o);
        end
        exm_valid = 1; exm_rd_we = 1; exm_rd = 3'd3; exm_result = 16'h0064;
        wb_valid = 1; wb_rd_we = 1; wb_rd = 3'd3; wb_result = 16'h0005;
        #1; vectors++;
        if (ex_a !== 16'h0064) begin
            miscompares++; $display("FAIL bypass_exm_priority: got %h want 0064", ex_a);
        end
        exm_valid = 0;
        #1; vectors++;
        if (ex_a !== 16'h0005) begin
            miscompares++; $display("FAIL bypass_wb: got %h want 0005", ex_a);
        end
        wb_rd = 3'd6;
        #1; vectors++;
        if ({ex_a, ex_b} !== {16'h0007, 16'h0005}) begin
            miscompares++; $display("FAIL bypass_rs2_wb: got %h want 00070005", {ex_a, ex_b});
        end
        idle_inputs();
        issue(4'b0000, 3'd0, 3'd1, 3'd2, 1'b1, 16'h00AA, 16'h00BB, 16'h0000, 1'b0);
        push_exp(16'h00AA, 16'h00BB, 4'b0000, 3'd2, 1'b1);
        step();
        id_valid = 0;
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL bypass_capture_r0: got %h want %h", obs_o, exp_o);
        end
        exm_valid = 1; exm_rd_we = 1; exm_rd = 3'd0; exm_result = 16'h0064;
        wb_valid = 1; wb_rd_we = 1; wb_rd = 3'd0; wb_result = 16'h0005;
        #1; vectors++;
        if (ex_a !== 16'h00AA) begin
            miscompares++; $display("FAIL bypass_r0: got %h want 00AA", ex_a);
        end
        idle_inputs();
    endtask
`else
    task automatic test_hazard();
        idle_inputs(); step();
        issue(4'b0000, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0011, 16'h0022, 16'h0000, 1'b0);
        push_exp(16'h0011, 16'h0022, 4'b0000, 3'd3, 1'b1);
        step();
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL hazard_producer: got %h want %h", obs_o, exp_o);
        end
        issue(4'b0000, 3'd3, 3'd2, 3'd4, 1'b1, 16'h0033, 16'h0044, 16'h0000, 1'b0);
        for (int s = 0; s < 3; s++) begin
            exm_valid = (s == 1); exm_rd_we = 1; exm_rd = 3'd3;
            wb_valid  = (s == 2); wb_rd_we  = 1; wb_rd  = 3'd3;
            #1; vectors++;
            if (id_ready !== 1'b0) begin
                miscompares++; $display("FAIL hazard_ready[%0d]: got %b want 0", s, id_ready);
            end
            step();
            vectors++;
            if (ex_valid !== 1'b0) begin
                miscompares++; $display("FAIL hazard_bubble[%0d]: got %b want 0", s, ex_valid);
            end
        end
        wb_valid = 0;
        #1; vectors++;
        if (id_ready !== 1'b1) begin
            miscompares++; $display("FAIL hazard_retired_ready: got %b want 1", id_ready);
        end
        push_exp(16'h0033, 16'h0044, 4'b0000, 3'd4, 1'b1);
        step();
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL hazard_capture: got %h want %h", obs_o, exp_o);
        end
        issue(4'b0010, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0055, 16'h0066, 16'h0000, 1'b0);
        push_exp(16'h0055, 16'h0066, 4'b0010, 3'd0, 1'b1);
        step();
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL hazard_r0_producer: got %h want %h", obs_o, exp_o);
        end
        issue(4'b0011, 3'd0, 3'd0, 3'd5, 1'b1, 16'h0077, 16'h0088, 16'h0000, 1'b0);
        exm_valid = 1; exm_rd_we = 1; exm_rd = 3'd0;
        #1; vectors++;
        if (id_ready !== 1'b1) begin
            miscompares++; $display("FAIL hazard_r0_ready: got %b want 1", id_ready);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_imm();
        idle_inputs(); step();
        exm_valid = 1; exm_rd_we = 1; exm_rd = 3'd4; exm_result = 16'h1234;
        issue(4'b0010, 3'd1, 3'd4, 3'd6, 1'b0, 16'h0101, 16'h0202, 16'hFFEC, 1'b1);
        #1; vectors++;
        if (id_ready !== 1'b1) begin
            miscompares++; $display("FAIL imm_ready: got %b want 1", id_ready);
        end
        push_exp(16'h0101, 16'hFFEC, 4'b0010, 3'd6, 1'b0);
        step();
        id_valid = 0;
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL imm_select: got %h want %h", obs_o, exp_o);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        idle_inputs(); step();
        issue(4'b0011, 3'd1, 3'd2, 3'd7, 1'b1, 16'hA5A5, 16'h5A5A, 16'h0000, 1'b0);
        push_exp(16'hA5A5, 16'h5A5A, 4'b0011, 3'd7, 1'b1);
        step();
        held_o = sb.pop_front(); vectors++;
        if (obs_o !== held_o) begin
            miscompares++; $display("FAIL stall_capture: got %h want %h", obs_o, held_o);
        end
        issue(4'b1001, 3'd2, 3'd1, 3'd1, 1'b1, 16'hDEAD, 16'hBEEF, 16'h1111, 1'b1);
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1; vectors++;
            if (id_ready !== 1'b0) begin
                miscompares++; $display("FAIL stall_ready[%0d]: got %b want 0", c, id_ready);
            end
            step();
            vectors++;
            if (obs_o !== held_o) begin
                miscompares++; $display("FAIL stall_hold[%0d]: got %h want %h", c, obs_o, held_o);
            end
        end
        flush = 1;
        step();
        vectors++;
        if ({ex_valid, ex_rd_we} !== 2'b00) begin
            miscompares++; $display("FAIL flush_over_stall: got %b want 00", {ex_valid, ex_rd_we});
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs(); step();
        issue(4'b0100, 3'd1, 3'd2, 3'd3, 1'b1, 16'h1357, 16'h2468, 16'h0000, 1'b0);
        flush = 1;
        step();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_kills_capture: got %b want 0", ex_valid);
        end
        flush = 0;
        push_exp(16'h1357, 16'h2468, 4'b0100, 3'd3, 1'b1);
        step();
        id_valid = 0;
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL flush_resume: got %h want %h", obs_o, exp_o);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        idle_inputs(); step();
        for (int i = 0; i < 4; i++) begin
            a = DW'($urandom); b = DW'($urandom);
            issue(OW'(i + 10), 3'd1, 3'd2, AW'(4 + i), i[0], a, b, 16'h0000, 1'b0);
            push_exp(a, b, OW'(i + 10), AW'(4 + i), i[0]);
            step();
            exp_o = sb.pop_front(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs_o, exp_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid_stall();
        idle_inputs(); step();
        issue(4'b0110, 3'd1, 3'd2, 3'd6, 1'b1, 16'hCAFE, 16'hF00D, 16'h0000, 1'b0);
        push_exp(16'hCAFE, 16'hF00D, 4'b0110, 3'd6, 1'b1);
        step();
        exp_o = sb.pop_front(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++; $display("FAIL rst_stall_capture: got %h want %h", obs_o, exp_o);
        end
        stall = 1;
        step();
        rst = 1;
        step();
        rst = 0; stall = 0; id_valid = 0;
        vectors++;
        if (obs_o !== '0) begin
            miscompares++; $display("FAIL rst_mid_stall: got %h want 0", obs_o);
        end
        step();
        vectors++;
        if (obs_o !== '0) begin
            miscompares++; $display("FAIL rst_no_survivor: got %h want 0", obs_o);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_capture();
`ifdef ID_EX_FWD_EN
        test_bypass();
`else
        test_hazard();
`endif
        test_imm();
        test_stall();
        test_flush();
        test_back_to_back();
        test_rst_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
